// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory access controller: access sizes, error codes,
// FSM states and the default per-beat timeout.
package mem_ctrl_pkg;

    localparam int DEFAULT_TIMEOUT_CYC = 15;

    typedef enum logic [1:0] {
        DT_BYTE   = 2'b00,
        DT_HALF   = 2'b01,
        DT_WORD   = 2'b10,
        DT_DOUBLE = 2'b11
    } data_type_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } err_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        BEAT1 = 3'd2,
        GAP   = 3'd3,
        BEAT2 = 3'd4,
        FIN   = 3'd5
    } state_e;

    // Natural alignment: each size must sit on a multiple of its own width.
    function automatic logic is_misaligned(input logic [1:0] dt, input logic [2:0] a);
        logic bad;
        bad = 1'b0;
        case (dt)
            DT_HALF:   bad = a[0];
            DT_WORD:   bad = |a[1:0];
            DT_DOUBLE: bad = |a;
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: little-endian load extraction plus store
// replication and byte enables for one 32-bit memory word.
module mem_lane_align
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  data_type,
    input  logic [1:0]  byte_off,
    input  logic [31:0] store_word,
    input  logic [31:0] load_word,
    output logic [3:0]  be,
    output logic [31:0] store_lanes,
    output logic [31:0] load_data
);

    always_comb begin
        be          = 4'b1111;
        store_lanes = store_word;
        load_data   = load_word;
        case (data_type)
            DT_BYTE: begin
                be          = 4'b0001 << byte_off;
                store_lanes = {4{store_word[7:0]}};
                load_data   = (load_word >> {byte_off, 3'b000}) & 32'h0000_00FF;
            end
            DT_HALF: begin
                be          = byte_off[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{store_word[15:0]}};
                load_data   = (load_word >> {byte_off[1], 4'b0000}) & 32'h0000_FFFF;
            end
            default: begin
                be          = 4'b1111;
                store_lanes = store_word;
                load_data   = load_word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: checks alignment, runs one or two handshaked beats
// with a per-beat timeout and reports completion with a registered done/err.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        rw,
    input  logic [1:0]  dataType,
    input  logic [31:0] addr,
    input  logic [63:0] wdata,
    output logic        mem_mfa,
    output logic [31:0] mem_addr,
    output logic        mem_rw,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_mfc,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic [31:0] rdata_hi,
    output logic [1:0]  err
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    state_e        state;
    logic          rw_q;
    logic [1:0]    dt_q;
    logic [31:0]   addr_q;
    logic [63:0]   wdata_q;
    logic [31:0]   lo_q;
    logic [CW-1:0] count;

    logic [31:0]   store_word;
    logic [3:0]    align_be;
    logic [31:0]   align_wdata;
    logic [31:0]   align_load;
    logic          beat_timeout;

    // GAP is the only state that launches the second beat, so it selects the upper word.
    assign store_word   = (state == GAP) ? wdata_q[63:32] : wdata_q[31:0];
    assign beat_timeout = (count == CW'(TIMEOUT_CYC - 1));

    mem_lane_align u_align (
        .data_type   (dt_q),
        .byte_off    (addr_q[1:0]),
        .store_word  (store_word),
        .load_word   (mem_rdata),
        .be          (align_be),
        .store_lanes (align_wdata),
        .load_data   (align_load)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            rw_q      <= 1'b0;
            dt_q      <= 2'b00;
            addr_q    <= '0;
            wdata_q   <= '0;
            lo_q      <= '0;
            count     <= '0;
            mem_mfa   <= 1'b0;
            mem_addr  <= '0;
            mem_rw    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdata     <= '0;
            rdata_hi  <= '0;
            err       <= ERR_OK;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rw_q    <= rw;
                        dt_q    <= dataType;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        mem_rw  <= rw;
                        busy    <= 1'b1;
                        state   <= CHECK;
                    end
                end

                CHECK: begin
                    if (is_misaligned(dt_q, addr_q[2:0])) begin
                        state    <= FIN;
                        done     <= 1'b1;
                        err      <= ERR_MISALIGN;
                        rdata    <= '0;
                        rdata_hi <= '0;
                    end else begin
                        state     <= BEAT1;
                        mem_mfa   <= 1'b1;
                        mem_addr  <= {addr_q[31:2], 2'b00};
                        mem_be    <= align_be;
                        mem_wdata <= rw_q ? 32'h0 : align_wdata;
                        count     <= '0;
                    end
                end

                BEAT1: begin
                    if (mem_mfc) begin
                        mem_mfa   <= 1'b0;
                        mem_be    <= 4'b0000;
                        mem_wdata <= '0;
                        if (dt_q == DT_DOUBLE) begin
                            lo_q  <= mem_rdata;
                            state <= GAP;
                        end else begin
                            state    <= FIN;
                            done     <= 1'b1;
                            err      <= ERR_OK;
                            rdata    <= rw_q ? align_load : 32'h0;
                            rdata_hi <= '0;
                        end
                    end else if (beat_timeout) begin
                        mem_mfa   <= 1'b0;
                        mem_be    <= 4'b0000;
                        mem_wdata <= '0;
                        count     <= count + 1'b1;
                        state     <= FIN;
                        done      <= 1'b1;
                        err       <= ERR_TIMEOUT;
                        rdata     <= '0;
                        rdata_hi  <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end

                GAP: begin
                    state     <= BEAT2;
                    mem_mfa   <= 1'b1;
                    mem_addr  <= {addr_q[31:2], 2'b00} + 32'd4;
                    mem_be    <= align_be;
                    mem_wdata <= rw_q ? 32'h0 : align_wdata;
                    count     <= '0;
                end

                BEAT2: begin
                    if (mem_mfc) begin
                        mem_mfa   <= 1'b0;
                        mem_be    <= 4'b0000;
                        mem_wdata <= '0;
                        state     <= FIN;
                        done      <= 1'b1;
                        err       <= ERR_OK;
                        rdata     <= rw_q ? lo_q : 32'h0;
                        rdata_hi  <= rw_q ? mem_rdata : 32'h0;
                    end else if (beat_timeout) begin
                        mem_mfa   <= 1'b0;
                        mem_be    <= 4'b0000;
                        mem_wdata <= '0;
                        count     <= count + 1'b1;
                        state     <= FIN;
                        done      <= 1'b1;
                        err       <= ERR_TIMEOUT;
                        rdata     <= '0;
                        rdata_hi  <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end

                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    mem_mfa <= 1'b0;
                    mem_be  <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl: loads, stores, doubleword
// beats, misalignment, timeout and mid-access reset.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        rw = 1'b0;
    logic [1:0]  dataType = 2'b00;
    logic [31:0] addr = '0;
    logic [63:0] wdata = '0;
    logic        mem_mfa;
    logic [31:0] mem_addr;
    logic        mem_rw;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_mfc = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic [31:0] rdata_hi;
    logic [1:0]  err;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT_CYC(15)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .rw        (rw),
        .dataType  (dataType),
        .addr      (addr),
        .wdata     (wdata),
        .mem_mfa   (mem_mfa),
        .mem_addr  (mem_addr),
        .mem_rw    (mem_rw),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_mfc   (mem_mfc),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .rdata_hi  (rdata_hi),
        .err       (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One-cycle start pulse; on return the controller sits in CHECK.
    task automatic applyStimulus(input logic l_rw, input logic [1:0] l_dt, input logic [31:0] l_addr, input logic [63:0] l_wdata);
        rw       = l_rw;
        dataType = l_dt;
        addr     = l_addr;
        wdata    = l_wdata;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        int mfa_cycles;
        int early_done;

        tick();
        tick();
        checkOutput("reset_ctrl", {mem_mfa, busy, done, mem_rw, err, mem_be}, 64'h0);
        checkOutput("reset_addr", mem_addr, 64'h0);
        checkOutput("reset_wdata", mem_wdata, 64'h0);
        checkOutput("reset_rdata", {rdata_hi, rdata}, 64'h0);
        reset_n = 1'b1;
        tick();

        // Byte load at 0x103: lane 3 comes back right-justified.
        applyStimulus(1'b1, 2'b00, 32'h0000_0103, 64'h0);
        checkOutput("bl_check", {busy, mem_mfa, done}, 64'b100);
        tick();
        checkOutput("bl_beat_ctrl", {mem_mfa, mem_rw, mem_be}, {58'h0, 1'b1, 1'b1, 4'b1000});
        checkOutput("bl_beat_addr", mem_addr, 64'h100);
        mem_mfc   = 1'b1;
        mem_rdata = 32'hAABB_CCDD;
        tick();
        mem_mfc = 1'b0;
        checkOutput("bl_fin_ctrl", {done, busy, mem_mfa, mem_be, err}, {55'h0, 1'b1, 1'b1, 1'b0, 4'b0000, 2'b00});
        checkOutput("bl_rdata", rdata, 64'h0000_00AA);
        tick();
        checkOutput("bl_idle", {done, busy}, 64'h0);
        checkOutput("bl_rdata_hold", rdata, 64'h0000_00AA);

        // Halfword store at 0x202, memory stalls one cycle.
        applyStimulus(1'b0, 2'b01, 32'h0000_0202, 64'h1234);
        tick();
        checkOutput("hs_be", mem_be, 64'b1100);
        checkOutput("hs_wdata", mem_wdata, 64'h1234_1234);
        checkOutput("hs_addr", mem_addr, 64'h200);
        checkOutput("hs_ctrl", {mem_mfa, mem_rw}, 64'b10);
        tick();
        checkOutput("hs_stall_addr", {mem_mfa, mem_addr}, {31'h0, 1'b1, 32'h200});
        mem_mfc = 1'b1;
        tick();
        mem_mfc = 1'b0;
        checkOutput("hs_fin", {done, err, mem_mfa}, {60'h0, 1'b1, 2'b00, 1'b0});
        tick();

        // Doubleword load at 0x08 over two beats with one idle gap.
        applyStimulus(1'b1, 2'b11, 32'h0000_0008, 64'h0);
        tick();
        checkOutput("dl_b1", {mem_mfa, mem_be, mem_addr}, {27'h0, 1'b1, 4'b1111, 32'h8});
        mem_mfc   = 1'b1;
        mem_rdata = 32'h1111_1111;
        tick();
        mem_mfc = 1'b0;
        checkOutput("dl_gap", {mem_mfa, mem_be, done, busy}, {57'h0, 1'b0, 4'b0000, 1'b0, 1'b1});
        mem_mfc   = 1'b1;
        mem_rdata = 32'h2222_2222;
        tick();
        checkOutput("dl_b2", {mem_mfa, mem_be, mem_addr}, {27'h0, 1'b1, 4'b1111, 32'hC});
        tick();
        mem_mfc = 1'b0;
        checkOutput("dl_fin", {done, err}, {61'h0, 1'b1, 2'b00});
        checkOutput("dl_rdata", {rdata_hi, rdata}, 64'h2222_2222_1111_1111);
        tick();

        // Misaligned word load: no memory cycle at all.
        applyStimulus(1'b1, 2'b10, 32'h0000_0006, 64'h0);
        checkOutput("mis_check_mfa", mem_mfa, 64'h0);
        tick();
        checkOutput("mis_fin", {done, err, mem_mfa, busy}, {59'h0, 1'b1, 2'b01, 1'b0, 1'b1});
        tick();
        checkOutput("mis_idle", {done, busy, mem_mfa}, 64'h0);

        // Byte store at 0x101 replicates to every lane, enables lane 1.
        applyStimulus(1'b0, 2'b00, 32'h0000_0101, 64'hA5);
        tick();
        checkOutput("bs_lanes", {mem_be, mem_wdata}, {28'h0, 4'b0010, 32'hA5A5_A5A5});
        mem_mfc = 1'b1;
        tick();
        mem_mfc = 1'b0;
        tick();

        // Halfword load at 0x102 takes the upper half.
        applyStimulus(1'b1, 2'b01, 32'h0000_0102, 64'h0);
        tick();
        checkOutput("hl_be", mem_be, 64'b1100);
        mem_mfc   = 1'b1;
        mem_rdata = 32'hAABB_CCDD;
        tick();
        mem_mfc = 1'b0;
        checkOutput("hl_rdata", {done, rdata}, {31'h0, 1'b1, 32'h0000_AABB});
        tick();

        // Doubleword store at 0x10: low word first, high word in the second beat.
        applyStimulus(1'b0, 2'b11, 32'h0000_0010, 64'h5566_7788_99AA_BBCC);
        tick();
        checkOutput("ds_b1", {mem_addr, mem_wdata}, 64'h0000_0010_99AA_BBCC);
        mem_mfc = 1'b1;
        tick();
        mem_mfc = 1'b0;
        tick();
        checkOutput("ds_b2", {mem_addr, mem_wdata}, 64'h0000_0014_5566_7788);
        checkOutput("ds_b2_be", {mem_mfa, mem_be}, {59'h0, 1'b1, 4'b1111});
        mem_mfc = 1'b1;
        tick();
        mem_mfc = 1'b0;
        checkOutput("ds_fin", {done, err}, {61'h0, 1'b1, 2'b00});
        tick();

        // Timeout: memory never answers; 15 beat cycles then error.
        applyStimulus(1'b1, 2'b00, 32'h0000_0020, 64'h0);
        tick();
        mfa_cycles = 0;
        early_done = 0;
        if (mem_mfa) mfa_cycles++;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (mem_mfa) mfa_cycles++;
            if (done) early_done++;
        end
        checkOutput("to_mfa_cycles", 64'(mfa_cycles), 64'd15);
        checkOutput("to_no_early_done", 64'(early_done), 64'd0);
        tick();
        checkOutput("to_fin", {done, err, mem_mfa, mem_be}, {57'h0, 1'b1, 2'b10, 1'b0, 4'b0000});
        tick();

        // Reset during BEAT1, with a second start while busy that must be dropped.
        applyStimulus(1'b1, 2'b10, 32'h0000_0040, 64'h0);
        start = 1'b1;
        addr  = 32'h0000_0080;
        tick();
        start = 1'b0;
        checkOutput("rst_busy_start_ignored", {mem_mfa, mem_addr}, {31'h0, 1'b1, 32'h40});
        reset_n = 1'b0;
        tick();
        checkOutput("rst_mid_ctrl", {mem_mfa, busy, done, mem_rw, err, mem_be}, 64'h0);
        checkOutput("rst_mid_data", {mem_addr, mem_wdata}, 64'h0);
        checkOutput("rst_mid_rdata", {rdata_hi, rdata}, 64'h0);
        reset_n = 1'b1;
        mem_mfc = 1'b1;
        early_done = 0;
        mfa_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) early_done++;
            if (mem_mfa || busy) mfa_cycles++;
        end
        mem_mfc = 1'b0;
        checkOutput("rst_no_done", 64'(early_done), 64'd0);
        checkOutput("rst_no_access", 64'(mfa_cycles), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 15, max cycles to wait for mem_mfc per beat.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 start  in  1  one-cycle access request from control unit; sampled only in IDLE.
REQ-005 rw  in  1  1 = load, 0 = store.
REQ-006 dataType  in  2  00 byte, 01 halfword, 10 word, 11 doubleword.
REQ-007 addr  in  32  byte address of access.
REQ-008 wdata  in  64  store data, right-justified; [63:32] used only for doubleword.
REQ-009 mem_mfa  out  1  memory function active (request valid to memory).
REQ-010 mem_addr  out  32  word-aligned memory address (low 2 bits = 0).
REQ-011 mem_rw  out  1  copy of latched rw.
REQ-012 mem_be  out  4  byte-lane enables, bit i = bits [8i+7:8i].
REQ-013 mem_wdata  out  32  lane-aligned store data.
REQ-014 mem_rdata  in  32  read data, valid when mem_mfc = 1.
REQ-015 mem_mfc  in  1  memory function complete.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle completion pulse.
REQ-018 rdata  out  32  load result, right-justified, zero-filled above size; feeds the sign-extension stage with dataType.
REQ-019 rdata_hi  out  32  second word of doubleword load; 0 otherwise.
REQ-020 err  out  2  valid with done: 00 ok, 01 misaligned, 10 timeout.

Function
REQ-021 FSM states: IDLE, CHECK, BEAT1, GAP, BEAT2, FIN.
REQ-022 IDLE: start=1 latches rw, dataType, addr, wdata -> CHECK; start while busy is ignored.
REQ-023 CHECK: misaligned (halfword addr[0]!=0; word addr[1:0]!=0; doubleword addr[2:0]!=0) -> FIN with err=01, no memory cycle; else -> BEAT1.
REQ-024 BEAT1/BEAT2: mem_mfa=1, mem_addr = {addr[31:2],2'b00} (+4 in BEAT2); held stable until mem_mfc=1.
REQ-025 On mem_mfc=1 in BEAT1: non-doubleword -> FIN; doubleword -> GAP (mem_mfa=0 for exactly one cycle) -> BEAT2.
REQ-026 On mem_mfc=1 in BEAT2 -> FIN.
REQ-027 Timeout counter clears on entry to each beat, increments each beat cycle without mem_mfc; reaching TIMEOUT_CYC -> FIN with err=10, mem_mfa dropped that same cycle.
REQ-028 FIN: done=1, err valid, rdata/rdata_hi stable; next cycle -> IDLE; outputs hold until next access reaches FIN.
REQ-029 Load lanes (little-endian): byte rdata = mem_rdata >> 8*addr[1:0], [7:0] kept; halfword >> 16*addr[1], [15:0] kept; word/doubleword unshifted.
REQ-030 Store lanes: byte replicated to all lanes, mem_be = 1<<addr[1:0]; halfword replicated, mem_be = addr[1]?1100:0011; word/doubleword mem_be = 1111, BEAT2 drives wdata[63:32].
REQ-031 mem_be = 0000 and mem_wdata = 0 when mem_mfa=0; for loads mem_be reflects accessed lanes.
REQ-032 Latency with mem_mfc on first beat cycle: single beat start->done 3 cycles; doubleword 5 cycles.
REQ-033 mem_mfc outside BEAT1/BEAT2 ignored.

Reset
REQ-034 reset_n=0 at a clock edge -> IDLE; mem_mfa, busy, done, mem_be, mem_wdata, mem_addr, mem_rw, rdata, rdata_hi, err, counter all 0.
REQ-035 Reset mid-access abandons it immediately; no done pulse issued.

Structure
REQ-036 Package mem_ctrl_pkg holds dataType encodings, err codes, FSM state enum, default TIMEOUT_CYC.
REQ-037 One combinational sub-module mem_lane_align performs load extraction and store replication/byte enables.

Verification
REQ-038 Byte load addr=0x103, mem_rdata=0xAABBCCDD, mfc on first cycle -> rdata=0x000000AA, err=00, done at cycle 3.
REQ-039 Halfword store addr=0x202, wdata=0x1234 -> mem_be=1100, mem_wdata=0x12341234, mem_addr=0x200.
REQ-040 Doubleword load addr=0x08, words 0x11111111/0x22222222 -> mem_addr 0x08 then 0x0C, one mfa-low GAP cycle, rdata/rdata_hi match, done at cycle 5.
REQ-041 Word load addr=0x06 -> err=01, done, mem_mfa never asserted.
REQ-042 Load with mem_mfc held 0 -> err=10 after 15 beat cycles, mem_mfa drops.
REQ-043 reset_n=0 during BEAT1; start asserted during busy -> IDLE with all outputs 0; start ignored, no extra access.
